// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution window reader.
package conv_pkg;

    localparam int IMG_DEF = 28;                 // image side in pixels
    localparam int K_DEF   = 5;                  // kernel side
    localparam int OUT_DEF = IMG_DEF - K_DEF + 1; // window positions per side
    localparam int AW      = 5;                  // column address width
    localparam int RW      = 5;                  // row counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/window_shift5.sv
// 5x5 binary window built from vertical 5-pixel column slices.
// Newest column lands in j=4; a band clear empties the window and restarts
// the column count so no column survives into the next row band.
module window_shift5 (
    input  logic        clk,
    input  logic        rst,
    input  logic        band_clr,
    input  logic        shift_en,
    input  logic [4:0]  col_in,
    output logic [24:0] win,
    output logic [4:0]  col_cnt
);

    logic [24:0] win_q, win_d;
    logic [4:0]  cnt_q, cnt_d;

    // Next window contents: clear at band start, otherwise shift left-by-column on capture.
    always_comb begin
        win_d = win_q;
        cnt_d = cnt_q;
        if (band_clr) begin
            win_d = '0;
            cnt_d = '0;
        end else if (shift_en) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    win_d[i*5+j] = win_q[i*5+j+1];
                end
                win_d[i*5+4] = col_in[i];
            end
            if (cnt_q != 5'd31) begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    // Window and column count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

    assign win     = win_q;
    assign col_cnt = cnt_q;

endmodule

// File: rtl/conv_window_reader.sv
// Scans a binary frame held in column-addressed RAM and streams every 5x5
// window in raster order. Each row band reads all columns, then idles for
// RD_LAT cycles so reads still in flight see the band's row select.
//
// state | meaning
// IDLE  | waiting for cal_start, no reads issued
// SCAN  | issuing one column read per cycle, column 0..IMG-1
// GAP   | holding address/row while the last RD_LAT reads return
module conv_window_reader
    import conv_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int IMG    = IMG_DEF,
    parameter int K      = K_DEF
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              cal_start,
    input  logic [4:0]        col_data,
    output logic [AW-1:0]     data_rd_addr,
    output logic [RW-1:0]     conv_row_cnt,
    output logic [24:0]       window,
    output logic              window_vld,
    output logic [RW-1:0]     win_row,
    output logic [AW-1:0]     win_col,
    output logic              frame_done,
    output logic              busy
);

    localparam int OUT = IMG - K + 1;

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [RW-1:0]   row_q;
    logic [1:0]      gap_q;
    logic            busy_q;

    logic [RD_LAT-1:0] pv_q;
    logic [AW-1:0]     pc_q [RD_LAT];

    logic            cap_vld;
    logic [AW-1:0]   cap_col;
    logic            band_clr;
    logic            win_ready;
    logic [24:0]     win_bits;
    logic [4:0]      col_cnt;

    logic            window_vld_q;
    logic            frame_done_q;
    logic [RW-1:0]   win_row_q;
    logic [AW-1:0]   win_col_q;

    // Sequencer: column address and row band walk, plus the busy flag.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            row_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (frame_done_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    // busy stays high through the last window, so a start
                    // arriving then is dropped rather than queued
                    if (cal_start && !busy_q) begin
                        state_q <= ST_SCAN;
                        addr_q  <= '0;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (addr_q == AW'(IMG - 1)) begin
                        state_q <= ST_GAP;
                        gap_q   <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 2'(RD_LAT - 1)) begin
                        if (row_q == RW'(OUT - 1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_SCAN;
                            row_q   <= row_q + 1'b1;
                            addr_q  <= '0;
                        end
                    end else begin
                        gap_q <= gap_q + 2'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read-return tracker: tags each returning slice with the column it was read from.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= (state_q == ST_SCAN);
            pc_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
        end
    end

    assign cap_vld   = pv_q[RD_LAT-1];
    assign cap_col   = pc_q[RD_LAT-1];
    assign band_clr  = (state_q == ST_SCAN) && (addr_q == '0);
    assign win_ready = cap_vld && (col_cnt >= 5'd4);

    window_shift5 u_shift (
        .clk      (sclk),
        .rst      (s_rst),
        .band_clr (band_clr),
        .shift_en (cap_vld),
        .col_in   (col_data),
        .win      (win_bits),
        .col_cnt  (col_cnt)
    );

    // Window strobe and coordinates, valid alongside the freshly shifted window.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            window_vld_q <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else begin
            window_vld_q <= win_ready;
            frame_done_q <= win_ready && (cap_col == AW'(IMG - 1)) && (row_q == RW'(OUT - 1));
            if (win_ready) begin
                win_row_q <= row_q;
                win_col_q <= cap_col - AW'(4);
            end
        end
    end

    assign data_rd_addr = addr_q;
    assign conv_row_cnt = row_q;
    assign window       = win_bits;
    assign window_vld   = window_vld_q;
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;

endmodule
